// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core definitions (word width, PC step, fetch state, fetch entry).
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd1;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Sequential word-addressed PC step; wraps naturally at 2^32.
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} entries with push, pop, flush and count.
// Flush takes priority over push and pop in the same cycle.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage -- fetch PC, req/ack instruction memory port, prefetch FIFO.
// Define FETCH_BYPASS_EN to forward an ack straight to decode when the FIFO is empty.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [WORD_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic              instr_valid_o,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
);
    localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned      SUM_W    = CNT_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0] FULL_SUM = SUM_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;

    logic              flush_c;
    logic              push_c;
    logic              pop_c;
    logic              accept_c;
    logic              fifo_empty_c;
    logic [CNT_W-1:0]  count;
    logic [SUM_W-1:0]  count_after_c;
    fetch_entry_t      head;
    fetch_entry_t      push_entry_c;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_c),
        .push_i      (push_c),
        .push_data_i (push_entry_c),
        .pop_i       (pop_c),
        .head_o      (head),
        .count_o     (count)
    );

    assign fifo_empty_c = (count == '0);
    assign accept_c     = (state_q == FS_WAIT) && mem_ack_i && !redirect_i;
    assign push_entry_c = '{pc: mem_addr_q, instr: mem_rdata_i};
    assign pop_c        = !fifo_empty_c && instr_ready_i;

`ifdef FETCH_BYPASS_EN
    logic bypass_c;

    // Empty FIFO: the returning word is shown to decode in its ack cycle and skips the FIFO if taken.
    assign bypass_c      = accept_c && fifo_empty_c;
    assign instr_valid_o = !fifo_empty_c || bypass_c;
    assign instr_o       = bypass_c ? mem_rdata_i : head.instr;
    assign instr_pc_o    = bypass_c ? mem_addr_q : head.pc;
    assign push_c        = accept_c && !(bypass_c && instr_ready_i);
`else
    assign instr_valid_o = !fifo_empty_c;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign push_c        = accept_c;
`endif

    // Occupancy after this cycle's push/pop decides whether the next request has a reserved slot.
    assign count_after_c = SUM_W'(count) + SUM_W'(push_c) - SUM_W'(pop_c);

    // Fetch FSM next state, PC and request address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        flush_c    = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                if (redirect_i) begin
                    flush_c    = 1'b1;
                    fetch_pc_d = redirect_pc_i;
                end else if (count < FULL_CNT) begin
                    state_d    = FS_WAIT;
                    mem_addr_d = fetch_pc_q;
                    fetch_pc_d = next_pc(fetch_pc_q);
                end
            end
            FS_WAIT: begin
                if (redirect_i) begin
                    flush_c    = 1'b1;
                    fetch_pc_d = redirect_pc_i;
                    state_d    = mem_ack_i ? FS_IDLE : FS_DROP;
                end else if (mem_ack_i) begin
                    if (count_after_c < FULL_SUM) begin
                        mem_addr_d = fetch_pc_q;
                        fetch_pc_d = next_pc(fetch_pc_q);
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
            end
            FS_DROP: begin
                if (redirect_i) begin
                    flush_c    = 1'b1;
                    fetch_pc_d = redirect_pc_i;
                end
                if (mem_ack_i) begin
                    state_d = FS_IDLE;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        mem_req_d = (state_d != FS_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based fetch model.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'd0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready)
    );

    int vectors = 0;
    int fails   = 0;

    // Reference model: a request in flight (busy), whether its data will be kept, the PC to fetch next
    // and the queue of fetched-but-unconsumed instructions.
    bit           m_busy;
    bit           m_keep;
    logic [31:0]  m_pc;
    logic [31:0]  m_addr;
    fetch_entry_t m_q[$];

    logic [97:0]  exp_vec;
    logic [97:0]  obs_vec;
    logic         obs_req;
    logic         obs_valid;
    logic [31:0]  obs_instr;
    logic [31:0]  obs_pc;
    logic [31:0]  obs_addr;

    task automatic model_reset();
        m_busy = 1'b0;
        m_keep = 1'b0;
        m_pc   = 32'd0;
        m_addr = 32'd0;
        m_q.delete();
    endtask

    // Drive one cycle of inputs, capture expected/observed outputs mid-cycle, advance the model.
    task automatic run_cycle(input logic redir, input logic [31:0] rpc, input logic ack,
                             input logic [31:0] rdata, input logic rdy);
        bit           byp;
        bit           e_valid;
        bit           pop;
        bit           push;
        bit           flush;
        int           sz;
        fetch_entry_t e_entry;
        logic [31:0]  cur_addr;

        redirect    = redir;
        redirect_pc = rpc;
        mem_ack     = ack;
        mem_rdata   = rdata;
        instr_ready = rdy;
        @(negedge clk);

        sz       = m_q.size();
        cur_addr = m_addr;
        byp      = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = m_busy && m_keep && ack && !redir && (sz == 0);
`endif
        e_valid = (sz > 0) || byp;
        if (sz > 0) e_entry = m_q[0];
        else        e_entry = '{pc: cur_addr, instr: rdata};
        exp_vec = {m_busy, m_busy ? cur_addr : 32'h0, e_valid,
                   e_valid ? {e_entry.instr, e_entry.pc} : 64'h0};
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        obs_valid = instr_valid;
        obs_instr = instr;
        obs_pc    = instr_pc;
        obs_vec = {mem_req, mem_req ? mem_addr : 32'h0, instr_valid,
                   instr_valid ? {instr, instr_pc} : 64'h0};

        pop   = (sz > 0) && rdy;
        push  = 1'b0;
        flush = 1'b0;
        if (m_busy) begin
            if (redir) begin
                flush = 1'b1;
                m_pc  = rpc;
                if (ack) m_busy = 1'b0;
                else     m_keep = 1'b0;
            end else if (ack) begin
                if (m_keep) begin
                    push = !(byp && rdy);
                    if (sz + int'(push) - int'(pop) < int'(DEPTH)) begin
                        m_addr = m_pc;
                        m_pc   = m_pc + 32'd1;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_busy = 1'b0;
                end
            end
        end else if (redir) begin
            flush = 1'b1;
            m_pc  = rpc;
        end else if (sz < int'(DEPTH)) begin
            m_busy = 1'b1;
            m_keep = 1'b1;
            m_addr = m_pc;
            m_pc   = m_pc + 32'd1;
        end

        if (flush) begin
            m_q.delete();
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back('{pc: cur_addr, instr: rdata});
        end

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        vectors++;
        if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        vectors++;
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        vectors++;
        if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", instr); end
        vectors++;
        if (instr_pc !== 32'h0) begin fails++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0, 32'h0, m_busy, $urandom, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL stream[%0d] got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_full();
        int acks = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (mem_req) acks++;
            run_cycle(1'b0, 32'h0, mem_req, $urandom, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL full[%0d] got %h want %h", i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (acks !== 4) begin fails++; $display("FAIL full_ack_count got %0d want 4", acks); end
        vectors++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL full_req_low got %b want 0", mem_req); end
        run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec) begin fails++; $display("FAIL full_pop got %h want %h", obs_vec, exp_vec); end
        for (int i = 0; i < 4 && !mem_req; i++) begin
            run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL full_refill[%0d] got %h want %h", i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin
            fails++;
            $display("FAIL full_next_req got req=%b addr=%h want req=1 addr=00000004", mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit          seen = 1'b0;
        bit          bad  = 1'b0;
        logic [31:0] first_pc = 32'hx;
        for (int i = 0; i < 10 && !m_busy; i++) run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        run_cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec) begin fails++; $display("FAIL rdw_redirect got %h want %h", obs_vec, exp_vec); end
        for (int i = 0; i < 15; i++) begin
            if (i < 2)       run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            else if (i == 2) run_cycle(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1);
            else             run_cycle(1'b0, 32'h0, m_busy, $urandom, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL rdw[%0d] got %h want %h", i, obs_vec, exp_vec);
            end
            if (obs_valid && obs_instr == 32'hDEADBEEF) bad = 1'b1;
            if (obs_valid && !seen) begin seen = 1'b1; first_pc = obs_pc; end
        end
        vectors++;
        if (bad || first_pc !== 32'h100) begin
            fails++;
            $display("FAIL rdw_first_pc got %h stale=%b want 00000100 stale=0", first_pc, bad);
        end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        for (int i = 0; i < 10 && m_q.size() < 2; i++) begin
            run_cycle(1'b0, 32'h0, m_busy, $urandom, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL rap_fill[%0d] got %h want %h", i, obs_vec, exp_vec); end
        end
        run_cycle(1'b1, 32'h40, m_busy, $urandom, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec) begin fails++; $display("FAIL rap_redirect got %h want %h", obs_vec, exp_vec); end
        run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
            fails++;
            $display("FAIL rap_flushed got valid=%b req=%b want valid=0 req=0", obs_valid, obs_req);
        end
        run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h40) begin
            fails++;
            $display("FAIL rap_new_req got req=%b addr=%h want req=1 addr=00000040", obs_req, obs_addr);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, m_busy, $urandom, 1'b0);
        for (int i = 0; i < 10 && !mem_req; i++) run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #2;
        vectors++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got req=%b valid=%b want 0 0", mem_req, instr_valid);
        end
        redirect = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 32'h0, m_busy, $urandom, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL async_resume[%0d] got %h want %h", i, obs_vec, exp_vec); end
            if (i == 1) begin
                vectors++;
                if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
                    fails++;
                    $display("FAIL async_resume_pc got req=%b addr=%h want req=1 addr=00000000", obs_req, obs_addr);
                end
            end
        end
    endtask

    task automatic test_wrap();
        run_cycle(1'b1, 32'hFFFF_FFFE, m_busy, $urandom, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec) begin fails++; $display("FAIL wrap_redirect got %h want %h", obs_vec, exp_vec); end
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 32'h0, m_busy, $urandom, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL wrap[%0d] got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0);
            run_cycle(r, {20'h0, 12'($urandom)}, m_busy && ($urandom_range(0, 1) == 1),
                      $urandom, ($urandom_range(0, 9) < 6));
            vectors++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random[%0d] got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
